// File: rtl/tdc_thermo_decoder.sv
// Thermometer-code reader for a tapped-delay-line TDC channel.
// Registers the raw tap sample, bubble-corrects it and detects the HIT
// leading edge. Each hit produces one {coarse, fine} timestamp on a
// single-entry valid/ready output. A hit that arrives while the previous
// timestamp is still waiting is dropped, pulses missed and sets sticky ovf.
module tdc_thermo_decoder #(
    parameter int NTAPS    = 64,
    parameter int FINE_W   = 7,
    parameter int COARSE_W = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [NTAPS-1:0]    Q,
    input  logic                enable,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                missed,
    output logic                ovf
);

    typedef enum logic {
        WAIT_LOW = 1'b0,
        ARMED    = 1'b1
    } state_t;

    logic [COARSE_W-1:0] coarse_reg;
    logic [NTAPS-1:0]    s_reg;
    logic [COARSE_W-1:0] cnt1_reg;
    logic [NTAPS-1:0]    c_next;
    logic [NTAPS-1:0]    c_reg;
    logic [COARSE_W-1:0] cnt2_reg;
    // fill_reg[1] is set once the correction stage holds a real sample
    // rather than the zeros left behind by clr.
    logic [1:0]          fill_reg;
    state_t              state_reg;
    state_t              state_next;
    logic [FINE_W-1:0]   fine;
    logic                hit;
    logic                load;
    logic                drop;
    logic                ts_valid_reg;
    logic [COARSE_W-1:0] ts_coarse_reg;
    logic [FINE_W-1:0]   ts_fine_reg;
    logic                missed_reg;
    logic                ovf_reg;

    // Free-running coarse time base; wraps silently.
    always_ff @(posedge clk) begin
        if (clr) begin
            coarse_reg <= '0;
        end else begin
            coarse_reg <= coarse_reg + 1'b1;
        end
    end

    // Bubble correction: end taps pass through, interior taps take the
    // 3-tap majority so a single flipped bit near the edge is repaired.
    assign c_next[0]       = s_reg[0];
    assign c_next[NTAPS-1] = s_reg[NTAPS-1];
    generate
        for (genvar gi = 1; gi < NTAPS - 1; gi++) begin : g_bubble
            assign c_next[gi] = (s_reg[gi-1] & s_reg[gi])
                              | (s_reg[gi]   & s_reg[gi+1])
                              | (s_reg[gi-1] & s_reg[gi+1]);
        end
    endgenerate

    // Two pipeline stages: raw sample, then corrected code, with the
    // coarse count travelling alongside.
    always_ff @(posedge clk) begin
        if (clr) begin
            s_reg    <= '0;
            cnt1_reg <= '0;
            c_reg    <= '0;
            cnt2_reg <= '0;
            fill_reg <= '0;
        end else begin
            s_reg    <= Q;
            cnt1_reg <= coarse_reg;
            c_reg    <= c_next;
            cnt2_reg <= cnt1_reg;
            fill_reg <= {fill_reg[0], 1'b1};
        end
    end

    // Fine time is the number of taps the edge has passed.
    always_comb begin
        fine = '0;
        for (int i = 0; i < NTAPS; i++) begin
            fine = fine + FINE_W'(c_reg[i]);
        end
    end

    // Detector state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= WAIT_LOW;
        end else begin
            state_reg <= state_next;
        end
    end

    // Edge detector. Only a low-to-high transition of tap 0 seen while
    // enabled is a hit; an edge that goes by while disabled is consumed so
    // that enabling during a long HIT does not fabricate an event.
    always_comb begin
        state_next = state_reg;
        hit        = 1'b0;
        if (fill_reg[1]) begin
            case (state_reg)
                WAIT_LOW: begin
                    if (!c_reg[0]) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (c_reg[0]) begin
                        hit        = enable;
                        state_next = WAIT_LOW;
                    end
                end
                default: state_next = WAIT_LOW;
            endcase
        end
    end

    assign load = hit && (!ts_valid_reg || ts_ready);
    assign drop = hit && ts_valid_reg && !ts_ready;

    // Single-entry output holding register with overflow reporting.
    always_ff @(posedge clk) begin
        if (clr) begin
            ts_valid_reg  <= 1'b0;
            ts_coarse_reg <= '0;
            ts_fine_reg   <= '0;
            missed_reg    <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            if (load) begin
                ts_valid_reg  <= 1'b1;
                ts_coarse_reg <= cnt2_reg;
                ts_fine_reg   <= fine;
            end else if (ts_valid_reg && ts_ready) begin
                ts_valid_reg  <= 1'b0;
            end
            missed_reg <= drop;
            if (drop) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign ts_valid  = ts_valid_reg;
    assign ts_coarse = ts_coarse_reg;
    assign ts_fine   = ts_fine_reg;
    assign missed    = missed_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Bench for tdc_thermo_decoder (NTAPS=8, FINE_W=4, COARSE_W=4).
// A cycle model in the driver predicts every output; expected timestamps
// go into a queue that an independent monitor pops on each transfer.
module tb_tdc_thermo_decoder;

    localparam int NT = 8;
    localparam int FW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic [NT-1:0] q = '0;
    logic          enable = 1'b0;
    logic          ts_ready = 1'b0;
    logic          ts_valid;
    logic [CW-1:0] ts_coarse;
    logic [FW-1:0] ts_fine;
    logic          missed;
    logic          ovf;

    tdc_thermo_decoder #(.NTAPS(NT), .FINE_W(FW), .COARSE_W(CW)) dut (
        .clk(clk), .clr(clr), .Q(q), .enable(enable),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
        .ts_fine(ts_fine), .missed(missed), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] co;
        logic [FW-1:0] fi;
    } ts_t;

    ts_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;

    // model: cur_* describe the cycle in progress, nxt_* the following one
    bit            cur_valid, cur_missed, cur_ovf;
    logic [CW-1:0] cur_co, cur_coarse;
    logic [FW-1:0] cur_fi;
    bit            nxt_valid = 0, nxt_missed = 0, nxt_ovf = 0;
    logic [CW-1:0] nxt_co = '0, nxt_coarse = '0;
    logic [FW-1:0] nxt_fi = '0;
    bit            seen_low = 0;
    logic [NT-1:0] q_d1 = '0, q_d2 = '0;
    logic [CW-1:0] co_d1 = '0, co_d2 = '0;
    bit            clr_d1 = 1, clr_d2 = 1;
    bit            started = 0;

    // monitor bookkeeping for directed checks
    int            xfers = 0;
    int            last_fine = -1, last_coarse = -1, prev_coarse = -1;

    task automatic check(input string name, input int got, input int exp);
        compared++;
        if (got != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Majority-of-three repair of interior taps, end taps unchanged.
    function automatic logic [NT-1:0] correct(input logic [NT-1:0] v);
        logic [NT-1:0] r;
        for (int i = 0; i < NT; i++) begin
            if (i == 0 || i == NT - 1) begin
                r[i] = v[i];
            end else begin
                r[i] = (int'(v[i-1]) + int'(v[i]) + int'(v[i+1])) >= 2;
            end
        end
        return r;
    endfunction

    // Drive one clock cycle of inputs and advance the model.
    task automatic step(input logic [NT-1:0] qv, input bit en, input bit rdy, input bit c);
        logic [NT-1:0] code;
        bit            ev;
        bit            real_s;
        @(posedge clk);
        #1;
        cur_valid  = nxt_valid;
        cur_missed = nxt_missed;
        cur_ovf    = nxt_ovf;
        cur_co     = nxt_co;
        cur_fi     = nxt_fi;
        cur_coarse = nxt_coarse;
        q = qv; enable = en; ts_ready = rdy; clr = c;
        real_s = !clr_d1 && !clr_d2;
        if (c) begin
            nxt_valid = 0; nxt_missed = 0; nxt_ovf = 0;
            nxt_co = '0; nxt_fi = '0; nxt_coarse = '0;
            seen_low = 0;
            exp_q.delete();
        end else begin
            ev = 0;
            code = correct(q_d2);
            if (real_s) begin
                if (!seen_low) begin
                    if (!code[0]) seen_low = 1;
                end else if (code[0]) begin
                    seen_low = 0;
                    ev = en;
                end
            end
            nxt_missed = 0;
            nxt_valid = cur_valid; nxt_co = cur_co; nxt_fi = cur_fi; nxt_ovf = cur_ovf;
            if (ev && (!cur_valid || rdy)) begin
                nxt_valid = 1;
                nxt_co = co_d2;
                nxt_fi = FW'($countones(code));
                exp_q.push_back('{co_d2, FW'($countones(code))});
            end else if (ev) begin
                nxt_missed = 1;
                nxt_ovf = 1;
            end else if (cur_valid && rdy) begin
                nxt_valid = 0;
            end
            nxt_coarse = cur_coarse + 1'b1;
        end
        q_d2 = q_d1; q_d1 = qv;
        co_d2 = co_d1; co_d1 = cur_coarse;
        clr_d2 = clr_d1; clr_d1 = c;
        started = 1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: compare every output each cycle, pop scoreboard on transfer.
    always @(negedge clk) begin
        if (started) begin
            check("ts_valid", int'(ts_valid), int'(cur_valid));
            check("missed", int'(missed), int'(cur_missed));
            check("ovf", int'(ovf), int'(cur_ovf));
            check("ts_coarse", int'(ts_coarse), int'(cur_co));
            check("ts_fine", int'(ts_fine), int'(cur_fi));
            if (ts_valid && ts_ready && !clr) begin
                xfers++;
                prev_coarse = last_coarse;
                last_coarse = int'(ts_coarse);
                last_fine = int'(ts_fine);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL sb_underflow: got transfer coarse=%0d fine=%0d expected none at %0t",
                             ts_coarse, ts_fine, $time);
                end else begin
                    ts_t e;
                    e = exp_q.pop_front();
                    check("sb_coarse", int'(ts_coarse), int'(e.co));
                    check("sb_fine", int'(ts_fine), int'(e.fi));
                end
            end
        end
    end

    initial begin
        int x0;
        int hold;
        logic [NT-1:0] rq;
        bit ren, rrdy, rclr;

        // reset
        step(8'h00, 1, 1, 1);
        step(8'h00, 1, 1, 1);

        // basic hit: 0x07 sampled at coarse 5
        x0 = xfers;
        for (int i = 0; i < 5; i++) step(8'h00, 1, 1, 0);
        step(8'h07, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(8'hFF, 1, 1, 0);
        settle();
        check("t1_count", xfers - x0, 1);
        check("t1_fine", last_fine, 3);
        check("t1_coarse", last_coarse, 5);

        // bubble: 0x2F repairs to 0x1F
        x0 = xfers;
        for (int i = 0; i < 3; i++) step(8'h00, 1, 1, 0);
        step(8'h2F, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(8'hFF, 1, 1, 0);
        settle();
        check("t2_count", xfers - x0, 1);
        check("t2_fine", last_fine, 5);

        // long HIT then rearm
        x0 = xfers;
        for (int i = 0; i < 20; i++) step(8'hFF, 1, 1, 0);
        settle();
        check("t3_long", xfers - x0, 0);
        step(8'h00, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(8'h01, 1, 1, 0);
        settle();
        check("t3_rearm", xfers - x0, 1);
        check("t3_fine", last_fine, 1);

        // backpressure: second hit dropped
        x0 = xfers;
        for (int i = 0; i < 3; i++) step(8'h00, 1, 0, 0);
        step(8'h07, 1, 0, 0);
        step(8'h00, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(8'h0F, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(8'h0F, 1, 1, 0);
        settle();
        check("t4_count", xfers - x0, 1);
        check("t4_fine", last_fine, 3);
        check("t4_ovf", int'(ovf), 1);
        check("t4_valid", int'(ts_valid), 0);

        // clr while a timestamp is pending and HIT is high
        x0 = xfers;
        for (int i = 0; i < 2; i++) step(8'h00, 1, 0, 0);
        step(8'h03, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(8'hFF, 1, 0, 0);
        step(8'hFF, 1, 1, 1);
        step(8'hFF, 1, 1, 1);
        for (int i = 0; i < 8; i++) step(8'hFF, 1, 1, 0);
        settle();
        check("t5_noevent", xfers - x0, 0);
        check("t5_ovf", int'(ovf), 0);
        step(8'h00, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(8'h03, 1, 1, 0);
        settle();
        check("t5_count", xfers - x0, 1);
        check("t5_fine", last_fine, 2);

        // coarse wrap
        x0 = xfers;
        for (int i = 0; i < 3; i++) step(8'h00, 1, 1, 0);
        while (nxt_coarse != 4'd15) step(8'h00, 1, 1, 0);
        step(8'h07, 1, 1, 0);
        step(8'h00, 1, 1, 0);
        step(8'h00, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(8'h07, 1, 1, 0);
        settle();
        check("t6_count", xfers - x0, 2);
        check("t6_wrap", prev_coarse, 15);
        check("t6_after", last_coarse, 2);

        // enable low during the edge, raised while HIT still high
        x0 = xfers;
        for (int i = 0; i < 3; i++) step(8'h00, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(8'hFF, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(8'hFF, 1, 1, 0);
        settle();
        check("t6_disabled", xfers - x0, 0);
        for (int i = 0; i < 2; i++) step(8'h00, 1, 1, 0);
        for (int i = 0; i < 5; i++) step(8'h01, 1, 1, 0);
        settle();
        check("t6_enabled", xfers - x0, 1);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 4) begin
                rq = '0;
            end else begin
                rq = NT'((1 << $urandom_range(1, NT)) - 1);
                if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, NT - 1)] ^= 1'b1;
            end
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                ren  = ($urandom_range(0, 9) != 0);
                rrdy = ($urandom_range(0, 2) != 0);
                rclr = ($urandom_range(0, 199) == 0);
                step(rq, ren, rrdy, rclr);
            end
        end

        // drain
        for (int i = 0; i < 6; i++) step(8'h00, 1, 1, 0);
        settle();
        check("sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
